cr_cdc_fifo_rd_unpack: RTL and testbench



---
 rtl/cr_cdc_fifo_rd_unpack_pkg.sv | 10 +
 rtl/cr_cdc_fifo_rd_unpack.sv | 89 ++++++++
 tb/tb_cr_cdc_fifo_rd_unpack.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_cdc_fifo_rd_unpack_pkg.sv
// Shared types for the CDC FIFO read-side unpack stage.
// Holds the holding-register state encoding.
package cr_cdc_fifo_rd_unpack_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } hold_state_t;

endpackage

// File: rtl/cr_cdc_fifo_rd_unpack.sv
// Drains wide FWFT FIFO words and emits them as narrow beats,
// least-significant slice first, at one beat per cycle.
module cr_cdc_fifo_rd_unpack
    import cr_cdc_fifo_rd_unpack_pkg::*;
#(
    parameter int N_DATA_BITS = 64,
    parameter int N_RATIO     = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fifo_empty,
    input  logic [N_DATA_BITS-1:0]           fifo_rdata,
    output logic                             fifo_ren,
    output logic                             out_valid,
    output logic [N_DATA_BITS/N_RATIO-1:0]   out_data,
    output logic                             out_last,
    input  logic                             out_ready,
    output logic                             busy
);

    localparam int N_OUT_BITS = N_DATA_BITS / N_RATIO;
    localparam int IDX_W      = (N_RATIO > 1) ? $clog2(N_RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RATIO - 1);

    if (N_RATIO < 1 || (N_DATA_BITS % N_RATIO) != 0) begin : g_bad_params
        $error("cr_cdc_fifo_rd_unpack: N_DATA_BITS must be a multiple of N_RATIO >= 1");
    end

    hold_state_t            hold_valid, hold_valid_n;
    logic [N_DATA_BITS-1:0] hold_data, hold_data_n;
    logic [IDX_W-1:0]       beat_idx, beat_idx_n;
    logic                   at_last;
    logic                   accept;
    logic                   load;

    assign at_last = (beat_idx == LAST_IDX);
    assign accept  = (hold_valid == SEND) && out_ready;
    // Reload on the final accepted beat keeps the stream bubble-free.
    assign load    = !fifo_empty && !rst &&
                     ((hold_valid == IDLE) || (out_ready && at_last));

    always_comb begin
        hold_valid_n = hold_valid;
        hold_data_n  = hold_data;
        beat_idx_n   = beat_idx;
        if (load) begin
            hold_valid_n = SEND;
            hold_data_n  = fifo_rdata;
            beat_idx_n   = '0;
        end else if (accept) begin
            if (at_last) begin
                hold_valid_n = IDLE;
                beat_idx_n   = '0;
            end else begin
                beat_idx_n   = beat_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= IDLE;
            beat_idx   <= '0;
        end else begin
            hold_valid <= hold_valid_n;
            beat_idx   <= beat_idx_n;
        end
    end

    always_ff @(posedge clk) begin
        hold_data <= hold_data_n;
    end

    assign fifo_ren  = load;
    assign out_valid = (hold_valid == SEND);
    assign busy      = out_valid;
    assign out_last  = out_valid && at_last;
    assign out_data  = hold_data[int'(beat_idx)*N_OUT_BITS +: N_OUT_BITS];

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        fifo_ren |-> !fifo_empty);

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_data) && $stable(out_last)));
`endif

endmodule

// File: tb/tb_cr_cdc_fifo_rd_unpack.sv
// Self-checking bench: three instances (ratio 2, 4, 1) fed by queue FIFOs,
// beats compared against an expected-slice scoreboard.
module tb_cr_cdc_fifo_rd_unpack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst_a, empty_a, ren_a, valid_a, last_a, ready_a, busy_a;
    logic [63:0] rdata_a;
    logic [31:0] data_a;

    logic        rst_b, empty_b, ren_b, valid_b, last_b, ready_b, busy_b;
    logic [63:0] rdata_b;
    logic [15:0] data_b;

    logic        rst_c, empty_c, ren_c, valid_c, last_c, ready_c, busy_c;
    logic [63:0] rdata_c;
    logic [63:0] data_c;

    cr_cdc_fifo_rd_unpack #(.N_DATA_BITS(64), .N_RATIO(2)) u_a (
        .clk(clk), .rst(rst_a), .fifo_empty(empty_a), .fifo_rdata(rdata_a),
        .fifo_ren(ren_a), .out_valid(valid_a), .out_data(data_a),
        .out_last(last_a), .out_ready(ready_a), .busy(busy_a));

    cr_cdc_fifo_rd_unpack #(.N_DATA_BITS(64), .N_RATIO(4)) u_b (
        .clk(clk), .rst(rst_b), .fifo_empty(empty_b), .fifo_rdata(rdata_b),
        .fifo_ren(ren_b), .out_valid(valid_b), .out_data(data_b),
        .out_last(last_b), .out_ready(ready_b), .busy(busy_b));

    cr_cdc_fifo_rd_unpack #(.N_DATA_BITS(64), .N_RATIO(1)) u_c (
        .clk(clk), .rst(rst_c), .fifo_empty(empty_c), .fifo_rdata(rdata_c),
        .fifo_ren(ren_c), .out_valid(valid_c), .out_data(data_c),
        .out_last(last_c), .out_ready(ready_c), .busy(busy_c));

    logic [63:0] fa[$], fb[$], fc[$];
    logic [64:0] ea[$], eb[$], ec[$];
    int          beats_c = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected beats of a word: slice k is bits [k*w +: w], last on k==r-1.
    task automatic push(input int id, input logic [63:0] w);
        int          r;
        int          ob;
        logic [63:0] mask;
        logic [64:0] e;
        r    = (id == 0) ? 2 : (id == 1) ? 4 : 1;
        ob   = 64 / r;
        mask = (ob == 64) ? '1 : ((64'd1 << ob) - 64'd1);
        for (int k = 0; k < r; k++) begin
            e = {(k == r - 1) ? 1'b1 : 1'b0, (w >> (k * ob)) & mask};
            if (id == 0) ea.push_back(e);
            else if (id == 1) eb.push_back(e);
            else ec.push_back(e);
        end
        if (id == 0) fa.push_back(w);
        else if (id == 1) fb.push_back(w);
        else fc.push_back(w);
    endtask

    task automatic refresh();
        empty_a = (fa.size() == 0);
        rdata_a = empty_a ? {$urandom, $urandom} : fa[0];
        empty_b = (fb.size() == 0);
        rdata_b = empty_b ? {$urandom, $urandom} : fb[0];
        empty_c = (fc.size() == 0);
        rdata_c = empty_c ? {$urandom, $urandom} : fc[0];
    endtask

    task automatic tick();
        logic        pa, pb, pc;
        logic [64:0] e;
        #1;
        chk("a_underflow", {63'd0, ren_a & empty_a}, 64'd0);
        chk("b_underflow", {63'd0, ren_b & empty_b}, 64'd0);
        chk("c_underflow", {63'd0, ren_c & empty_c}, 64'd0);
        chk("a_busy", {63'd0, busy_a}, {63'd0, valid_a});
        if (valid_a && ready_a) begin
            if (ea.size() == 0) chk("a_extra_beat", 64'd1, 64'd0);
            else begin
                e = ea.pop_front();
                chk("a_beat_data", {32'd0, data_a}, e[63:0]);
                chk("a_beat_last", {63'd0, last_a}, {63'd0, e[64]});
            end
        end
        if (valid_b && ready_b) begin
            if (eb.size() == 0) chk("b_extra_beat", 64'd1, 64'd0);
            else begin
                e = eb.pop_front();
                chk("b_beat_data", {48'd0, data_b}, e[63:0]);
                chk("b_beat_last", {63'd0, last_b}, {63'd0, e[64]});
            end
        end
        if (valid_c && ready_c) begin
            beats_c++;
            if (ec.size() == 0) chk("c_extra_beat", 64'd1, 64'd0);
            else begin
                e = ec.pop_front();
                chk("c_beat_data", data_c, e[63:0]);
                chk("c_beat_last", {63'd0, last_c}, 64'd1);
            end
        end
        pa = ren_a;
        pb = ren_b;
        pc = ren_c;
        @(posedge clk);
        #1;
        if (pa && fa.size() > 0) void'(fa.pop_front());
        if (pb && fb.size() > 0) void'(fb.pop_front());
        if (pc && fc.size() > 0) void'(fc.pop_front());
        refresh();
        #1;
    endtask

    initial begin
        logic [31:0] held;
        int          n;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ready_a = 1'b1; ready_b = 1'b0; ready_c = 1'b0;
        push(0, 64'h1111_2222_3333_4444);
        push(0, 64'hAAAA_BBBB_CCCC_DDDD);
        refresh();

        // Reset held with a non-empty FIFO: no pop, no valid.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ren", {63'd0, ren_a}, 64'd0);
            chk("rst_valid", {63'd0, valid_a}, 64'd0);
            chk("rst_last", {63'd0, last_a}, 64'd0);
        end
        chk("rst_no_pop", 64'(fa.size()), 64'd2);

        rst_a = 1'b0;
        #1;
        chk("first_pop", {63'd0, ren_a}, 64'd1);
        tick();
        chk("b2b_beat0", {32'd0, data_a}, 64'h3333_4444);
        chk("b2b_beat0_last", {63'd0, last_a}, 64'd0);
        chk("b2b_beat0_ren", {63'd0, ren_a}, 64'd0);
        tick();
        chk("b2b_beat1", {32'd0, data_a}, 64'h1111_2222);
        chk("b2b_beat1_last", {63'd0, last_a}, 64'd1);
        chk("b2b_beat1_ren", {63'd0, ren_a}, 64'd1);
        tick();
        chk("b2b_beat2", {32'd0, data_a}, 64'hCCCC_DDDD);
        chk("b2b_beat2_ren", {63'd0, ren_a}, 64'd0);
        tick();
        chk("b2b_beat3", {32'd0, data_a}, 64'hAAAA_BBBB);
        chk("b2b_beat3_last", {63'd0, last_a}, 64'd1);
        chk("b2b_empty_ren", {63'd0, ren_a}, 64'd0);
        tick();
        chk("b2b_idle", {63'd0, valid_a}, 64'd0);
        chk("b2b_drained", 64'(ea.size()), 64'd0);

        // Backpressure on the last beat of a word.
        push(0, 64'h0123_4567_89AB_CDEF);
        push(0, 64'hFEDC_BA98_7654_3210);
        refresh();
        tick();
        tick();
        ready_a = 1'b0;
        #1;
        chk("bp_beat1", {32'd0, data_a}, 64'h0123_4567);
        held = data_a;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {63'd0, valid_a}, 64'd1);
            chk("bp_data", {32'd0, data_a}, {32'd0, held});
            chk("bp_last", {63'd0, last_a}, 64'd1);
            chk("bp_ren", {63'd0, ren_a}, 64'd0);
        end
        ready_a = 1'b1;
        #1;
        chk("bp_resume_ren", {63'd0, ren_a}, 64'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("bp_drained", 64'(ea.size()), 64'd0);
        chk("bp_idle", {63'd0, valid_a}, 64'd0);

        // Mid-word reset on the 4-beat instance.
        push(1, 64'h4444_3333_2222_1111);
        push(1, 64'h8888_7777_6666_5555);
        refresh();
        rst_b = 1'b0;
        ready_b = 1'b1;
        tick();
        chk("mw_beat0", {48'd0, data_b}, 64'h1111);
        tick();
        chk("mw_beat1", {48'd0, data_b}, 64'h2222);
        ready_b = 1'b0;
        rst_b = 1'b1;
        #1;
        chk("mw_rst_ren", {63'd0, ren_b}, 64'd0);
        tick();
        chk("mw_rst_valid", {63'd0, valid_b}, 64'd0);
        chk("mw_rst_last", {63'd0, last_b}, 64'd0);
        chk("mw_next_kept", 64'(fb.size()), 64'd1);
        for (int i = 0; i < 3; i++) void'(eb.pop_front());
        rst_b = 1'b0;
        ready_b = 1'b1;
        #1;
        chk("mw_repop", {63'd0, ren_b}, 64'd1);
        tick();
        chk("mw_new_beat0", {48'd0, data_b}, 64'h5555);
        chk("mw_new_valid", {63'd0, valid_b}, 64'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("mw_drained", 64'(eb.size()), 64'd0);

        // Random traffic and backpressure on the ratio-2 instance.
        for (int i = 0; i < 300; i++) begin
            if (fa.size() < 3 && ($urandom % 3) != 0)
                push(0, {$urandom, $urandom});
            refresh();
            ready_a = (($urandom % 3) != 0);
            tick();
        end
        ready_a = 1'b1;
        n = 0;
        while ((ea.size() > 0 || valid_a) && n < 100) begin
            tick();
            n++;
        end
        chk("rand_drained", 64'(ea.size()), 64'd0);
        chk("rand_bound", {63'd0, n >= 100}, 64'd0);

        // Ratio-1 passthrough: 1000 random words, random ready.
        rst_c = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (n < 1000 && fc.size() < 3 && ($urandom % 4) != 0) begin
                push(2, {$urandom, $urandom});
                n++;
            end
            refresh();
            ready_c = (($urandom % 4) != 0);
            tick();
            if (n == 1000 && ec.size() == 0 && !valid_c) break;
        end
        chk("pt_words", 64'(n), 64'd1000);
        chk("pt_beats", 64'(beats_c), 64'd1000);
        chk("pt_drained", 64'(ec.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
